// File: rtl/shared_div_arbiter.sv
// Two-requester arbiter in front of one shared iterative divider, with round-robin tie-break.
// Latency: accept at T, div_start at T+1, done no earlier than T+2, result valid at T+3.
// Backpressure: one op in flight; a held result blocks new grants until the owner consumes it.
module shared_div_arbiter #(
  parameter int XLEN     = 64,
  parameter int RS_DEPTH = 4,
  parameter int IW       = $clog2(RS_DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,

  input  logic            rs0_valid_i,
  output logic            rs0_ready_o,
  input  logic [IW-1:0]   rs0_idx_i,
  input  logic [XLEN-1:0] rs0_a_i,
  input  logic [XLEN-1:0] rs0_b_i,
  output logic            rs0_valid_o,
  input  logic            rs0_ready_i,
  output logic [IW-1:0]   rs0_idx_o,
  output logic [XLEN-1:0] rs0_result_o,

  input  logic            rs1_valid_i,
  output logic            rs1_ready_o,
  input  logic [IW-1:0]   rs1_idx_i,
  input  logic [XLEN-1:0] rs1_a_i,
  input  logic [XLEN-1:0] rs1_b_i,
  output logic            rs1_valid_o,
  input  logic            rs1_ready_i,
  output logic [IW-1:0]   rs1_idx_o,
  output logic [XLEN-1:0] rs1_result_o,

  output logic            div_start_o,
  output logic            div_abort_o,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  input  logic            div_done_i,
  input  logic [XLEN-1:0] div_result_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_q;
  logic            last_grant_q;
  logic            owner_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [IW-1:0]   idx_q;
  logic [XLEN-1:0] result_q;

  logic            grant_vld;
  logic            grant_id;
  logic            accept_en;
  logic [XLEN-1:0] a_d;
  logic [XLEN-1:0] b_d;
  logic [IW-1:0]   idx_d;
  logic            owner_rdy;
  logic            hold_out;

  // Pick the requester to grant: single valid wins, a tie goes to the one not served last
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (rs0_valid_i && rs1_valid_i) begin
      grant_vld = 1'b1;
      grant_id  = ~last_grant_q;
    end else if (rs0_valid_i) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (rs1_valid_i) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  // Acceptance is suppressed while reset is held so ready stays low even if requesters are valid
  assign accept_en   = rst_n_i && (state_q == IDLE) && !flush_i && grant_vld;
  assign rs0_ready_o = accept_en && !grant_id;
  assign rs1_ready_o = accept_en &&  grant_id;

  assign a_d       = grant_id ? rs1_a_i   : rs0_a_i;
  assign b_d       = grant_id ? rs1_b_i   : rs0_b_i;
  assign idx_d     = grant_id ? rs1_idx_i : rs0_idx_i;
  assign owner_rdy = owner_q  ? rs1_ready_i : rs0_ready_i;

  // Start is masked by a coincident flush so start and abort never overlap
  assign div_start_o = (state_q == START) && !flush_i;
  assign div_abort_o = flush_i && ((state_q == START) || (state_q == BUSY));
  assign div_a_o     = a_q;
  assign div_b_o     = b_q;

  // A flush in HOLD withdraws the result in the same cycle, so no handshake can complete
  assign hold_out     = (state_q == HOLD) && !flush_i;
  assign rs0_valid_o  = hold_out && !owner_q;
  assign rs1_valid_o  = hold_out &&  owner_q;
  assign rs0_idx_o    = rs0_valid_o ? idx_q    : '0;
  assign rs0_result_o = rs0_valid_o ? result_q : '0;
  assign rs1_idx_o    = rs1_valid_o ? idx_q    : '0;
  assign rs1_result_o = rs1_valid_o ? result_q : '0;

  // Arbitration FSM and operand/result latches; flush drops everything except the round-robin bit
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      idx_q        <= '0;
      result_q     <= '0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_en) begin
            owner_q      <= grant_id;
            last_grant_q <= grant_id;
            a_q          <= a_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            state_q      <= START;
          end
        end
        START: begin
          state_q <= BUSY;
        end
        BUSY: begin
          if (div_done_i) begin
            result_q <= div_result_i;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (owner_rdy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
